param_transpose_buffer: RTL and testbench

PARAM_TRANSPOSE_BUFFER -- requirements
Module: param_transpose_buffer

---
 rtl/param_transpose_buffer.sv | 104 ++++++++++
 tb/tb_param_transpose_buffer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_transpose_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : param_transpose_buffer
//  Purpose  : Double-banked N x N row-to-column transpose buffer with
//             valid/ready handshakes on both sides and zero padding of
//             partial blocks.
//  Revision : 1.0  initial release
// ============================================================================
module param_transpose_buffer #(
    parameter int N = 8,
    parameter int W = 11
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_valid,
    input  logic [N*W-1:0] i_data,
    input  logic           i_last,
    output logic           o_ready,
    output logic           o_valid,
    output logic [N*W-1:0] o_data,
    output logic           o_last,
    input  logic           i_ready
);

    localparam int c_cnt_w = $clog2(N);
    localparam int c_rc_w  = $clog2(N + 1);
    localparam logic [c_cnt_w-1:0] c_last_idx = c_cnt_w'(N - 1);
    localparam logic [c_rc_w-1:0]  c_rc_full  = c_rc_w'(N);

    localparam logic [0:0] c_FREE = 1'b0;
    localparam logic [0:0] c_FULL = 1'b1;

    logic [W-1:0]        r_bank  [2][N][N];
    logic [0:0]          r_state [2];
    logic [c_rc_w-1:0]   r_rc    [2];
    logic                r_wb;
    logic                r_rb;
    logic [c_cnt_w-1:0]  r_wr;
    logic [c_cnt_w-1:0]  r_cc;

    logic w_in_hs;
    logic w_out_hs;
    logic w_close;

    assign o_ready  = (r_state[r_wb] == c_FREE);
    assign o_valid  = (r_state[r_rb] == c_FULL);
    assign o_last   = o_valid && (r_cc == c_last_idx);
    assign w_in_hs  = i_valid && o_ready;
    assign w_out_hs = o_valid && i_ready;
    assign w_close  = (r_wr == c_last_idx) || i_last;

    // Bank memory is never reset; a FREE state masks stale contents.
    always_ff @(posedge i_clk) begin
        if (w_in_hs) begin
            for (int k = 0; k < N; k++) begin
                r_bank[r_wb][r_wr][k] <= i_data[k*W +: W];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state[0] <= c_FREE;
            r_state[1] <= c_FREE;
            r_rc[0]    <= c_rc_full;
            r_rc[1]    <= c_rc_full;
            r_wb       <= 1'b0;
            r_rb       <= 1'b0;
            r_wr       <= '0;
            r_cc       <= '0;
        end else begin
            // A write needs state[wb] FREE and a read needs state[rb] FULL,
            // so both updates below always touch different banks.
            if (w_in_hs) begin
                if (w_close) begin
                    r_state[r_wb] <= c_FULL;
                    r_rc[r_wb]    <= c_rc_w'(r_wr) + c_rc_w'(1);
                    r_wr          <= '0;
                    r_wb          <= ~r_wb;
                end else begin
                    r_wr <= r_wr + c_cnt_w'(1);
                end
            end
            if (w_out_hs) begin
                if (r_cc == c_last_idx) begin
                    r_state[r_rb] <= c_FREE;
                    r_cc          <= '0;
                    r_rb          <= ~r_rb;
                end else begin
                    r_cc <= r_cc + c_cnt_w'(1);
                end
            end
        end
    end

    // Lanes beyond the block's row count read as zero; idle output is zero.
    for (genvar r = 0; r < N; r++) begin : g_lane
        localparam logic [c_rc_w-1:0] c_row = c_rc_w'(r);
        assign o_data[r*W +: W] = (o_valid && (c_row < r_rc[r_rb]))
                                  ? r_bank[r_rb][r][r_cc] : '0;
    end

endmodule
`default_nettype wire

// File: tb/tb_param_transpose_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_param_transpose_buffer
//  Purpose  : Self-checking bench for param_transpose_buffer (N=8, W=11).
//  Revision : 1.0  initial release
// ============================================================================
module tb_param_transpose_buffer;

    localparam int N = 8;
    localparam int W = 11;

    logic           i_clk;
    logic           i_rst;
    logic           i_valid;
    logic [N*W-1:0] i_data;
    logic           i_last;
    logic           o_ready;
    logic           o_valid;
    logic [N*W-1:0] o_data;
    logic           o_last;
    logic           i_ready;

    param_transpose_buffer #(.N(N), .W(W)) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_valid (i_valid),
        .i_data  (i_data),
        .i_last  (i_last),
        .o_ready (o_ready),
        .o_valid (o_valid),
        .o_data  (o_data),
        .o_last  (o_last),
        .i_ready (i_ready)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [N*W-1:0] data;
        logic           last;
    } col_t;

    col_t           sb_q[$];
    logic [N*W-1:0] rows [N];
    int             n_rows = 0;
    logic           prev_stall = 1'b0;
    logic [N*W-1:0] prev_data;
    logic           prev_last;

    task automatic chk(input string name, input logic [N*W-1:0] act, input logic [N*W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [N*W-1:0] pattern_row(input int r);
        logic [N*W-1:0] d;
        for (int k = 0; k < N; k++) d[k*W +: W] = W'(r * N + k);
        return d;
    endfunction

    function automatic logic [N*W-1:0] random_row();
        logic [N*W-1:0] d;
        for (int k = 0; k < N; k++) d[k*W +: W] = W'($urandom);
        return d;
    endfunction

    // Reference model and scoreboard, evaluated mid-cycle on stable signals.
    always @(negedge i_clk) begin
        if (i_rst) begin
            sb_q.delete();
            n_rows     = 0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && o_valid) begin
                chk("hold_data", o_data, prev_data);
                chk("hold_last", o_last, prev_last);
            end
            prev_stall = o_valid && !i_ready;
            prev_data  = o_data;
            prev_last  = o_last;
            if (o_valid && i_ready) begin
                if (sb_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL sb_extra_column: got %h expected none", o_data);
                end else begin
                    col_t e;
                    e = sb_q.pop_front();
                    chk("sb_data", o_data, e.data);
                    chk("sb_last", o_last, e.last);
                end
            end
            if (i_valid && o_ready) begin
                rows[n_rows] = i_data;
                n_rows++;
                if (n_rows == N || i_last) begin
                    for (int c = 0; c < N; c++) begin
                        col_t e;
                        e.data = '0;
                        for (int r = 0; r < n_rows; r++) e.data[r*W +: W] = rows[r][c*W +: W];
                        e.last = (c == N - 1);
                        sb_q.push_back(e);
                    end
                    n_rows = 0;
                end
            end
        end
    end

    task automatic drive(input logic v, input logic l, input logic rd, input logic [N*W-1:0] d);
        i_valid = v;
        i_last  = l;
        i_ready = rd;
        i_data  = d;
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drain(input string name);
        drive(1'b0, 1'b0, 1'b1, '0);
        for (int i = 0; i < 200 && sb_q.size() != 0; i++) tick();
        chk({name, "_sb_empty"}, N*W'(sb_q.size()), '0);
        chk({name, "_idle"}, o_valid, 1'b0);
    endtask

    task automatic send_rows(input int cnt, input int first);
        for (int r = 0; r < cnt; r++) begin
            drive(1'b1, 1'b0, 1'b0, pattern_row(first + r));
            tick();
        end
        drive(1'b0, 1'b0, 1'b0, '0);
    endtask

    typedef struct {
        logic v, l, rd;
        int   row;
        logic e_rdy, e_val, e_lst;
    } vec_t;

    vec_t tbl [29];

    initial begin
        for (int i = 0; i < 8; i++)   tbl[i] = '{1'b1, 1'b0, 1'b1, i, 1'b1, 1'b0, 1'b0};
        for (int i = 8; i < 16; i++)  tbl[i] = '{1'b0, 1'b0, 1'b1, 0, 1'b1, 1'b1, (i == 15)};
        tbl[16] = '{1'b0, 1'b0, 1'b1, 0, 1'b1, 1'b0, 1'b0};
        for (int i = 17; i < 20; i++) tbl[i] = '{1'b1, (i == 19), 1'b1, i - 17, 1'b1, 1'b0, 1'b0};
        for (int i = 20; i < 28; i++) tbl[i] = '{1'b0, 1'b0, 1'b1, 0, 1'b1, 1'b1, (i == 27)};
        tbl[28] = '{1'b0, 1'b0, 1'b1, 0, 1'b1, 1'b0, 1'b0};

        i_rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, '0);
        tick();
        tick();
        @(negedge i_clk);
        chk("rst_valid", o_valid, 1'b0);
        chk("rst_ready", o_ready, 1'b1);
        chk("rst_last",  o_last,  1'b0);
        chk("rst_data",  o_data,  '0);
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;

        // Full block then a 3-row partial block, control checked per cycle
        for (int i = 0; i < 29; i++) begin
            drive(tbl[i].v, tbl[i].l, tbl[i].rd, tbl[i].v ? pattern_row(tbl[i].row) : '0);
            @(negedge i_clk);
            chk($sformatf("tbl%0d_ready", i), o_ready, tbl[i].e_rdy);
            chk($sformatf("tbl%0d_valid", i), o_valid, tbl[i].e_val);
            chk($sformatf("tbl%0d_last", i),  o_last,  tbl[i].e_lst);
            @(posedge i_clk);
            #1;
        end
        drain("tbl");

        // Four back-to-back blocks at full rate
        for (int i = 0; i < 4*N + N; i++) begin
            drive(i < 4*N, 1'b0, 1'b1, random_row());
            @(negedge i_clk);
            if (i < 4*N) chk($sformatf("stream%0d_ready", i), o_ready, 1'b1);
            if (i >= N)  chk($sformatf("stream%0d_valid", i), o_valid, 1'b1);
            @(posedge i_clk);
            #1;
        end
        drain("stream");

        // Fill both banks with the output stalled, then release one bank
        for (int i = 0; i <= 2*N; i++) begin
            drive(1'b1, (i == 2*N), 1'b0, random_row());
            @(negedge i_clk);
            chk($sformatf("fill%0d_ready", i), o_ready, (i < 2*N));
            @(posedge i_clk);
            #1;
        end
        for (int i = 0; i < N; i++) begin
            drive(1'b0, 1'b0, 1'b1, '0);
            @(negedge i_clk);
            chk($sformatf("release%0d_ready", i), o_ready, 1'b0);
            @(posedge i_clk);
            #1;
        end
        @(negedge i_clk);
        chk("release_ready_back", o_ready, 1'b1);
        chk("release_valid", o_valid, 1'b1);
        @(posedge i_clk);
        #1;
        drain("release");

        // Reset after five rows, then a fresh block
        send_rows(5, 40);
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        @(negedge i_clk);
        chk("midrst_valid", o_valid, 1'b0);
        chk("midrst_ready", o_ready, 1'b1);
        @(posedge i_clk);
        #1;
        send_rows(N, 0);
        drain("after_midrst");

        // Reset while draining a block, then a fresh block
        send_rows(N, 10);
        drive(1'b0, 1'b0, 1'b1, '0);
        tick();
        tick();
        tick();
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, '0);
        @(negedge i_clk);
        chk("drainrst_valid", o_valid, 1'b0);
        chk("drainrst_data",  o_data,  '0);
        @(posedge i_clk);
        #1;
        send_rows(N, 20);
        drain("after_drainrst");

        // Random traffic with a forced three-cycle output stall
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
                  (i >= 100 && i < 103) ? 1'b0 : ($urandom_range(0, 3) != 0), random_row());
            tick();
        end
        drain("random");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
